rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of deassertion synchronizer flops (legal range 2..4).
REQ-002 Parameter: HOLD_CYCLES, default 16, cycles reset outputs stay asserted after a synchronized release (legal range 1..255).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: sw_rst_req  input  1  software reset request, synchronous to clk, level, 4-phase with sw_rst_ack.
REQ-006 Port: sw_rst_ack  output  1  software reset acknowledge.
REQ-007 Port: rst_out_n  output  1  downstream reset, active-low, async assert, sync deassert.
REQ-008 Port: rst_out_sync  output  1  downstream reset, active-high, fully synchronous, for sync-reset flops.
REQ-009 Port: ready  output  1  high only in RUN state.

Function
REQ-010 The block SHALL implement FSM states SYNC, HOLD, RUN, SW_HOLD, SW_ACK.
REQ-011 SYNC: shift 1 into the SYNC_STAGES chain each edge; when the chain's last stage is 1, load the counter with HOLD_CYCLES-1 and enter HOLD.
REQ-012 HOLD: decrement the counter each edge; at counter 0 enter RUN.
REQ-013 rst_out_n and rst_out_sync SHALL be deasserted only in RUN and SW_ACK; ready SHALL be 1 only in RUN.
REQ-014 Latency: with rst released before edge 1, rst_out_n and rst_out_sync SHALL deassert after edge SYNC_STAGES+HOLD_CYCLES and ready SHALL assert on the same edge (defaults: edge 18).
REQ-015 RUN with sw_rst_req=1 sampled: next state SW_HOLD, counter loaded HOLD_CYCLES-1, both resets asserted and ready=0 from that edge.
REQ-016 SW_HOLD: decrement each edge; at counter 0 enter SW_ACK with sw_rst_ack=1; sw_rst_req changes during SW_HOLD are ignored (full hold always completes).
REQ-017 SW_ACK: hold sw_rst_ack=1 until sw_rst_req sampled 0, then enter RUN with sw_rst_ack=0 and ready=1 on the same edge.
REQ-018 sw_rst_req already 0 on SW_ACK entry: SW_ACK SHALL last exactly one cycle (one-cycle ack pulse).
REQ-019 sw_rst_req held 1 on RUN re-entry SHALL NOT re-trigger; a new request requires req sampled 0 in RUN first (edge-armed).
REQ-020 The counter SHALL be $clog2(HOLD_CYCLES+1) bits wide and never wrap below 0.

Reset
REQ-021 rst low SHALL asynchronously force rst_out_n=0, rst_out_sync=1, ready=0, sw_rst_ack=0, synchronizer chain all 0, counter 0, state SYNC, re-arm flag 1.
REQ-022 rst low in any state, including SW_HOLD/SW_ACK, SHALL abort the operation immediately; no ack is issued for the aborted request.
REQ-023 rst pulse shorter than one clk period SHALL still produce the full SYNC+HOLD sequence.

Configuration
REQ-024 Macro RST_SEQ_SW_RST_EN defined: software reset path (REQ-015..019) compiled in.
REQ-025 Macro RST_SEQ_SW_RST_EN undefined: sw_rst_req ignored, sw_rst_ack tied 0, SW_HOLD/SW_ACK absent; ports unchanged.

Verification
REQ-026 Power-up: rst=0 for 3 cycles, release -> rst_out_n=0/rst_out_sync=1 through edge 17, both deasserted and ready=1 after edge 18 (defaults).
REQ-027 Async assert: rst falls mid-cycle in RUN -> rst_out_n=0, rst_out_sync=1, ready=0 before next clk edge.
REQ-028 SW reset: in RUN drive sw_rst_req=1 for 20 cycles -> resets asserted 16 cycles, then sw_rst_ack=1 until req drops, ready=1 next edge.
REQ-029 Short request: sw_rst_req=1 for one cycle -> full 16-cycle hold, one-cycle sw_rst_ack pulse, then RUN.
REQ-030 Abort: rst=0 at SW_HOLD count 5 -> immediate reset, sw_rst_ack never asserts, full 18-edge restart sequence.
REQ-031 Build without RST_SEQ_SW_RST_EN: sw_rst_req=1 in RUN -> no change on any output for 50 cycles.

Source files
------------

// File: rtl/rst_seq.sv
// Reset sequencer: synchronizes rst release, holds downstream resets for HOLD_CYCLES,
// and optionally services a software reset request (enabled by `define RST_SEQ_SW_RST_EN).
module rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_rst_req,
    output logic sw_rst_ack,
    output logic rst_out_n,
    output logic rst_out_sync,
    output logic ready
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] ST_SYNC    = 3'd0;
    localparam logic [2:0] ST_HOLD    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
`ifdef RST_SEQ_SW_RST_EN
    localparam logic [2:0] ST_SW_HOLD = 3'd3;
    localparam logic [2:0] ST_SW_ACK  = 3'd4;
`endif

    // state is kept as a plain named register so checkers can bind to it directly
    logic [2:0]             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_nxt;
    logic                   released_nxt;

`ifdef RST_SEQ_SW_RST_EN
    // sw_rst_req/sw_rst_ack is a 4-phase level handshake: req rises, ack rises after the
    // full hold, req falls, ack falls. A new request is taken only after req was seen low in RUN.
    logic armed, armed_nxt;
`else
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef RST_SEQ_SW_RST_EN
        armed_nxt = armed;
`endif
        case (state)
            // Leave SYNC on the edge the 1 lands in the last stage, so release costs SYNC_STAGES edges.
            ST_SYNC: begin
                if (sync_q[SYNC_STAGES-2]) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) state_nxt = ST_RUN;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_RUN: begin
`ifdef RST_SEQ_SW_RST_EN
                if (!sw_rst_req) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    state_nxt = ST_SW_HOLD;
                    cnt_nxt   = CNT_LOAD;
                    armed_nxt = 1'b0;
                end
`endif
            end
`ifdef RST_SEQ_SW_RST_EN
            // Request changes are ignored here: the full hold always runs out.
            ST_SW_HOLD: begin
                if (cnt == '0) state_nxt = ST_SW_ACK;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_SW_ACK: begin
                if (!sw_rst_req) state_nxt = ST_RUN;
            end
`endif
            default: state_nxt = ST_SYNC;
        endcase
    end

    always_comb begin
        released_nxt = (state_nxt == ST_RUN);
        ack_nxt      = 1'b0;
`ifdef RST_SEQ_SW_RST_EN
        released_nxt = released_nxt || (state_nxt == ST_SW_ACK);
        ack_nxt      = (state_nxt == ST_SW_ACK);
`endif
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_SYNC;
            cnt          <= '0;
            sync_q       <= '0;
            rst_out_n    <= 1'b0;
            rst_out_sync <= 1'b1;
            ready        <= 1'b0;
            sw_rst_ack   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            rst_out_n    <= released_nxt;
            rst_out_sync <= !released_nxt;
            ready        <= (state_nxt == ST_RUN);
            sw_rst_ack   <= ack_nxt;
        end
    end

`ifdef RST_SEQ_SW_RST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed <= 1'b1;
        else      armed <= armed_nxt;
    end
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with default parameters; the software reset steps run only
// when RST_SEQ_SW_RST_EN is defined for the build, otherwise the ignore-request steps run.
module tb_rst_seq;

    logic clk;
    logic rst;
    logic sw_rst_req;
    logic sw_rst_ack;
    logic rst_out_n;
    logic rst_out_sync;
    logic ready;

    int n_tests = 0;
    int n_fail  = 0;

    // {rst_out_n, rst_out_sync, ready, sw_rst_ack}
    localparam logic [3:0] V_RST = 4'b0100;
    localparam logic [3:0] V_RUN = 4'b1010;
    localparam logic [3:0] V_ACK = 4'b1001;

    rst_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_rst_req   (sw_rst_req),
        .sw_rst_ack   (sw_rst_ack),
        .rst_out_n    (rst_out_n),
        .rst_out_sync (rst_out_sync),
        .ready        (ready)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {rst_out_n, rst_out_sync, ready, sw_rst_ack};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // advance n rising edges, checking the outputs 1ns after each
    task automatic edges_chk(input int n, input string tag, input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk(tag, exp);
        end
    endtask

    // release rst before the next edge, then expect the 18-edge startup sequence
    task automatic release_and_check(input string tag);
        @(negedge clk);
        rst = 1'b1;
        edges_chk(17, {tag, "_held"}, V_RST);
        edges_chk(1, {tag, "_edge18"}, V_RUN);
    endtask

    initial begin
        rst        = 1'b0;
        sw_rst_req = 1'b0;

        // power-up
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", V_RST);
        release_and_check("powerup");
        edges_chk(3, "run_steady", V_RUN);

`ifdef RST_SEQ_SW_RST_EN
        // long request: 20 cycles high
        @(negedge clk);
        sw_rst_req = 1'b1;
        edges_chk(16, "sw_long_hold", V_RST);
        edges_chk(4, "sw_long_ack", V_ACK);
        @(negedge clk);
        sw_rst_req = 1'b0;
        edges_chk(1, "sw_long_done", V_RUN);
        edges_chk(2, "sw_long_run", V_RUN);

        // one-cycle request
        @(negedge clk);
        sw_rst_req = 1'b1;
        edges_chk(1, "sw_short_enter", V_RST);
        @(negedge clk);
        sw_rst_req = 1'b0;
        edges_chk(15, "sw_short_hold", V_RST);
        edges_chk(1, "sw_short_ack", V_ACK);
        edges_chk(2, "sw_short_done", V_RUN);

        // abort at SW_HOLD count 5
        @(negedge clk);
        sw_rst_req = 1'b1;
        edges_chk(1, "abort_enter", V_RST);
        @(negedge clk);
        sw_rst_req = 1'b0;
        edges_chk(10, "abort_hold", V_RST);
        rst = 1'b0;
        #1;
        chk("abort_async", V_RST);
        release_and_check("abort_restart");
        edges_chk(2, "abort_run", V_RUN);
`else
        // request must be ignored when the software path is compiled out
        @(negedge clk);
        sw_rst_req = 1'b1;
        edges_chk(50, "sw_ignored", V_RUN);
        @(negedge clk);
        sw_rst_req = 1'b0;
        edges_chk(1, "sw_ignored_after", V_RUN);
`endif

        // async assert mid-cycle in RUN
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_assert", V_RST);
        repeat (2) @(posedge clk);
        #1;
        chk("async_held", V_RST);
        release_and_check("async_restart");

        // sub-cycle rst pulse between edges
        @(posedge clk);
        #2;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("short_pulse_assert", V_RST);
        edges_chk(17, "short_pulse_held", V_RST);
        edges_chk(1, "short_pulse_edge18", V_RUN);
        edges_chk(2, "final_run", V_RUN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
